// File: rtl/spi_reg_bank_if.sv
// SPI pin bundle between an external controller and spi_reg_bank.
// Controller drives nCS/SCLK/COPI; the peripheral drives CIPO.
interface spi_reg_bank_if;
  logic nCS;
  logic SCLK;
  logic COPI;
  logic CIPO;

  modport master (
    output nCS,
    output SCLK,
    output COPI,
    input  CIPO
  );

  modport slave (
    input  nCS,
    input  SCLK,
    input  COPI,
    output CIPO
  );
endinterface

// File: rtl/spi_reg_bank.sv
// SPI peripheral register bank: framed writes, framing errors, write strobe.
// Define SPI_REG_READBACK_EN to enable register read-back over CIPO.
module spi_reg_bank #(
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 8,
  parameter int NUM_REGS    = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  spi_reg_bank_if.slave              spi,
  output logic [NUM_REGS*DATA_W-1:0] regs_o,
  output logic                       wr_stb,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic                       frame_err
);
  localparam int S         = SYNC_STAGES;
  localparam int FRAME_LEN = 1 + ADDR_W + DATA_W;
  localparam int CNT_W     = $clog2(FRAME_LEN + S + 2);

  typedef enum logic [2:0] {
    WAIT_CS, IDLE, CMD, DATA, WAIT_END, COMMIT
  } state_t;

  state_t state_q, state_d;

  logic [S:0]   ncs_sync_q, ncs_sync_d;
  logic [S:0]   sclk_sync_q, sclk_sync_d;
  logic [S-1:0] copi_sync_q, copi_sync_d;
  logic ncs_rise_q, ncs_rise_d;
  logic ncs_fall_q, ncs_fall_d;
  logic sclk_rise_q, sclk_rise_d;
  logic copi_bit_q, copi_bit_d;

  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [FRAME_LEN-1:0]      sh_q, sh_d, sh_shift;
  logic [NUM_REGS*DATA_W-1:0] regs_q, regs_d;
  logic                      wr_stb_q, wr_stb_d;
  logic [ADDR_W-1:0]         wr_addr_q, wr_addr_d;
  logic                      err_q, err_d;
  logic                      frame_err_q, frame_err_d;
  logic                      fall_hold_q, fall_hold_d;
  logic                      hit;

  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_data;

  // Edge flags come from the two oldest taps and are registered once more.
  always_comb begin
    ncs_sync_d  = {ncs_sync_q[S-1:0], spi.nCS};
    sclk_sync_d = {sclk_sync_q[S-1:0], spi.SCLK};
    copi_sync_d = {copi_sync_q[S-2:0], spi.COPI};
    ncs_rise_d  = ncs_sync_q[S-1] & ~ncs_sync_q[S];
    ncs_fall_d  = ~ncs_sync_q[S-1] & ncs_sync_q[S];
    sclk_rise_d = sclk_sync_q[S-1] & ~sclk_sync_q[S];
    copi_bit_d  = copi_sync_q[S-1];
  end

  assign sh_shift = {sh_q[FRAME_LEN-2:0], copi_bit_q};
  assign c_addr   = sh_q[DATA_W +: ADDR_W];
  assign c_data   = sh_q[DATA_W-1:0];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sh_d        = sh_q;
    regs_d      = regs_q;
    wr_stb_d    = 1'b0;
    wr_addr_d   = wr_addr_q;
    err_d       = 1'b0;
    frame_err_d = err_q;
    fall_hold_d = 1'b0;
    hit         = 1'b0;
    unique case (state_q)
      WAIT_CS: begin
        // Let the synchroniser refill before trusting nCS.
        if (cnt_q != CNT_W'(S + 1)) begin
          cnt_d = cnt_q + 1'b1;
        end else if (ncs_sync_q[S] && ncs_sync_q[S-1]) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      IDLE: begin
        if (ncs_fall_q || fall_hold_q) begin
          state_d = CMD;
          cnt_d   = '0;
          sh_d    = '0;
        end
      end
      CMD: begin
        if (ncs_rise_q) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (sclk_rise_q) begin
          sh_d = sh_shift;
          if (cnt_q == CNT_W'(ADDR_W)) begin
            state_d = DATA;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (ncs_rise_q) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (sclk_rise_q) begin
          sh_d = sh_shift;
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
            state_d = WAIT_END;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      WAIT_END: begin
        if (sclk_rise_q) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (ncs_rise_q) begin
          state_d = COMMIT;
        end
      end
      COMMIT: begin
        fall_hold_d = ncs_fall_q;
        state_d     = IDLE;
        if (sh_q[FRAME_LEN-1]) begin
          for (int i = 0; i < NUM_REGS; i++) begin
            if (c_addr == ADDR_W'(i)) begin
              regs_d[i*DATA_W +: DATA_W] = c_data;
              hit = 1'b1;
            end
          end
        end
        if (hit) begin
          wr_stb_d  = 1'b1;
          wr_addr_d = c_addr;
        end
      end
      default: state_d = WAIT_CS;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ncs_sync_q  <= '1;
      sclk_sync_q <= '0;
      copi_sync_q <= '0;
      ncs_rise_q  <= 1'b0;
      ncs_fall_q  <= 1'b0;
      sclk_rise_q <= 1'b0;
      copi_bit_q  <= 1'b0;
      state_q     <= WAIT_CS;
      cnt_q       <= '0;
      sh_q        <= '0;
      regs_q      <= '0;
      wr_stb_q    <= 1'b0;
      wr_addr_q   <= '0;
      err_q       <= 1'b0;
      frame_err_q <= 1'b0;
      fall_hold_q <= 1'b0;
    end else begin
      ncs_sync_q  <= ncs_sync_d;
      sclk_sync_q <= sclk_sync_d;
      copi_sync_q <= copi_sync_d;
      ncs_rise_q  <= ncs_rise_d;
      ncs_fall_q  <= ncs_fall_d;
      sclk_rise_q <= sclk_rise_d;
      copi_bit_q  <= copi_bit_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sh_q        <= sh_d;
      regs_q      <= regs_d;
      wr_stb_q    <= wr_stb_d;
      wr_addr_q   <= wr_addr_d;
      err_q       <= err_d;
      frame_err_q <= frame_err_d;
      fall_hold_q <= fall_hold_d;
    end
  end

  assign regs_o    = regs_q;
  assign wr_stb    = wr_stb_q;
  assign wr_addr   = wr_addr_q;
  assign frame_err = frame_err_q;

`ifdef SPI_REG_READBACK_EN
  logic              sclk_fall_q, sclk_fall_d;
  logic              cipo_q, cipo_d;
  logic              load_rd;
  logic [DATA_W-1:0] tx_q, tx_d, rd_data;

  assign sclk_fall_d = ~sclk_sync_q[S-1] & sclk_sync_q[S];
  assign load_rd = (state_q == CMD) && (state_d == DATA)
                && !sh_shift[ADDR_W];

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (sh_shift[ADDR_W-1:0] == ADDR_W'(i)) begin
        rd_data = regs_q[i*DATA_W +: DATA_W];
      end
    end
  end

  // The first DATA falling edge re-presents the MSB loaded at CMD exit.
  always_comb begin
    tx_d   = tx_q;
    cipo_d = cipo_q;
    if (load_rd) begin
      tx_d   = rd_data;
      cipo_d = rd_data[DATA_W-1];
    end else if (state_d != DATA) begin
      tx_d   = '0;
      cipo_d = 1'b0;
    end else if (sclk_fall_q) begin
      cipo_d = tx_q[DATA_W-1];
      tx_d   = {tx_q[DATA_W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_fall_q <= 1'b0;
      cipo_q      <= 1'b0;
      tx_q        <= '0;
    end else begin
      sclk_fall_q <= sclk_fall_d;
      cipo_q      <= cipo_d;
      tx_q        <= tx_d;
    end
  end

  assign spi.CIPO = cipo_q;
`else
  assign spi.CIPO = 1'b0;
`endif
endmodule

// File: tb/tb_spi_reg_bank.sv
// Directed bench for spi_reg_bank: writes, reads, framing errors, reset.
// Expected values are hand-computed from the frame contents.
module tb_spi_reg_bank;
  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [39:0] regs_o;
  logic        wr_stb;
  logic [6:0]  wr_addr;
  logic        frame_err;

  spi_reg_bank_if spi();

  spi_reg_bank dut (
    .clk       (clk),
    .rst       (rst),
    .spi       (spi),
    .regs_o    (regs_o),
    .wr_stb    (wr_stb),
    .wr_addr   (wr_addr),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int rise_cyc = 0;
  int stb_n   = 0;
  int err_n   = 0;
  int stb_cyc = 0;
  logic [6:0] stb_addr = '0;
  logic [7:0] rx;
  logic [7:0] rd_exp;
  int stb0, err0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wr_stb) begin
      stb_n++;
      stb_cyc  = cyc;
      stb_addr = wr_addr;
    end
    if (frame_err) err_n++;
  end

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic half();
    repeat (8) @(negedge clk);
  endtask

  task automatic cs_low();
    @(negedge clk);
    spi.nCS = 1'b0;
    half();
  endtask

  task automatic shift(input logic [31:0] v, input int n,
                       output logic [7:0] r);
    r = '0;
    for (int i = n - 1; i >= 0; i--) begin
      spi.COPI = v[i];
      half();
      spi.SCLK = 1'b1;
      r = {r[6:0], spi.CIPO};
      half();
      spi.SCLK = 1'b0;
    end
  endtask

  task automatic cs_high();
    half();
    spi.nCS  = 1'b1;
    spi.COPI = 1'b0;
    rise_cyc = cyc + 1;
    repeat (20) @(negedge clk);
  endtask

  task automatic frame(input logic [31:0] v, input int n,
                       output logic [7:0] r);
    cs_low();
    shift(v, n, r);
    cs_high();
  endtask

  initial begin
`ifdef SPI_REG_READBACK_EN
    rd_exp = 8'h80;
`else
    rd_exp = 8'h00;
`endif
    spi.nCS  = 1'b1;
    spi.SCLK = 1'b0;
    spi.COPI = 1'b0;
    rst      = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_regs", 64'(regs_o), 64'h0);
    check("rst_cipo", 64'(spi.CIPO), 64'h0);
    check("rst_stb", 64'(wr_stb), 64'h0);
    check("rst_addr", 64'(wr_addr), 64'h0);
    check("rst_err", 64'(frame_err), 64'h0);
    repeat (10) @(negedge clk);

    frame(32'h8055, 16, rx);
    check("w0_regs", 64'(regs_o), 64'h55);
    check("w0_stb_n", 64'(stb_n), 64'd1);
    check("w0_addr", 64'(stb_addr), 64'd0);
    check("w0_lat", 64'(stb_cyc - rise_cyc), 64'(LAT));
    check("w0_err_n", 64'(err_n), 64'd0);

    frame(32'h8480, 16, rx);
    check("w4_regs", 64'(regs_o), 64'h80_0000_0055);
    check("w4_addr", 64'(stb_addr), 64'd4);
    check("w4_lat", 64'(stb_cyc - rise_cyc), 64'(LAT));
    frame(32'h0400, 16, rx);
    check("r4_data", 64'(rx), 64'(rd_exp));
    check("r4_regs", 64'(regs_o), 64'h80_0000_0055);
    check("r4_stb_n", 64'(stb_n), 64'd2);
    check("r4_addr_held", 64'(wr_addr), 64'd4);
    check("r4_cipo_idle", 64'(spi.CIPO), 64'h0);

    frame(32'h81A, 12, rx);
    check("short_err_n", 64'(err_n), 64'd1);
    check("short_stb_n", 64'(stb_n), 64'd2);
    check("short_regs", 64'(regs_o), 64'h80_0000_0055);
    frame(32'h8103, 16, rx);
    check("w1_regs", 64'(regs_o), 64'h80_0000_0355);
    check("w1_addr", 64'(stb_addr), 64'd1);

    frame(32'h100EE, 17, rx);
    check("ovr_err_n", 64'(err_n), 64'd2);
    check("ovr_stb_n", 64'(stb_n), 64'd3);
    check("ovr_regs", 64'(regs_o), 64'h80_0000_0355);

    frame(32'h8AFF, 16, rx);
    check("oor_regs", 64'(regs_o), 64'h80_0000_0355);
    check("oor_stb_n", 64'(stb_n), 64'd3);
    check("oor_err_n", 64'(err_n), 64'd2);
    frame(32'h0A00, 16, rx);
    check("oor_rd", 64'(rx), 64'h0);

    stb0 = stb_n;
    err0 = err_n;
    cs_low();
    shift(32'h106, 9, rx);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    shift(32'h44, 7, rx);
    cs_high();
    check("mid_rst_regs", 64'(regs_o), 64'h0);
    check("mid_rst_stb", 64'(stb_n - stb0), 64'd0);
    check("mid_rst_err", 64'(err_n - err0), 64'd0);
    frame(32'h8211, 16, rx);
    check("w2_regs", 64'(regs_o), 64'h00_0011_0000);
    check("w2_stb", 64'(stb_n - stb0), 64'd1);
    check("w2_addr", 64'(stb_addr), 64'd2);
    check("w2_lat", 64'(stb_cyc - rise_cyc), 64'(LAT));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
